// File: rtl/bright_cmd_ctrl.sv
// UART brightness command controller: parses "Bhh\r" set and "?\r" query commands
// and answers through a 4-byte response buffer streamed to the UART transmitter.
module bright_cmd_ctrl #(
    parameter logic [7:0]  DEFAULT_BRIGHT = 8'h80,
    parameter logic [15:0] TIMEOUT        = 16'd15360
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rdsig,
    input  logic [7:0] rxdata,
    input  logic       tx_busy,
    output logic       wrsig,
    output logic [7:0] txdata,
    output logic [7:0] brightness,
    output logic       cmd_valid
);

    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [3:0] {
        RX_IDLE,
        RX_D1,
        RX_D2,
        RX_CR,
        Q_CR,
        ERR_DRAIN,
        TX_LOAD,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0]      hi_q, hi_d;
    logic [7:0]      val_q, val_d;
    logic [3:0][7:0] resp_q, resp_d;
    logic [7:0]      bright_q, bright_d;
    logic [7:0]      txdata_q, txdata_d;
    logic            wrsig_q, wrsig_d;
    logic            cmd_valid_q, cmd_valid_d;
    logic [4:0]      dec;
    logic            timed;

    // ASCII hex digit decode: {valid, nibble}
    function automatic logic [4:0] hex_dec(input logic [7:0] b);
        logic [7:0] t;
        t = 8'h00;
        if (b >= 8'h30 && b <= 8'h39) begin
            t = b - 8'h30;
            return {1'b1, t[3:0]};
        end
        if (b >= 8'h41 && b <= 8'h46) begin
            t = b - 8'h37;
            return {1'b1, t[3:0]};
        end
        if (b >= 8'h61 && b <= 8'h66) begin
            t = b - 8'h57;
            return {1'b1, t[3:0]};
        end
        return 5'b0_0000;
    endfunction

    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RX_IDLE;
            cnt_q       <= 16'd0;
            idx_q       <= 2'd0;
            hi_q        <= 4'd0;
            val_q       <= 8'd0;
            resp_q      <= '0;
            bright_q    <= DEFAULT_BRIGHT;
            txdata_q    <= 8'h00;
            wrsig_q     <= 1'b0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            hi_q        <= hi_d;
            val_q       <= val_d;
            resp_q      <= resp_d;
            bright_q    <= bright_d;
            txdata_q    <= txdata_d;
            wrsig_q     <= wrsig_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        hi_d        = hi_q;
        val_d       = val_q;
        resp_d      = resp_q;
        bright_d    = bright_q;
        txdata_d    = txdata_q;
        wrsig_d     = 1'b0;
        cmd_valid_d = 1'b0;
        dec         = hex_dec(rxdata);
        timed       = 1'b0;

        case (state_q)
            RX_IDLE: begin
                cnt_d = 16'd0;
                if (rdsig) begin
                    if (rxdata == 8'h42 || rxdata == 8'h62) begin
                        state_d = RX_D1;
                    end else if (rxdata == 8'h3F) begin
                        state_d = Q_CR;
                    end else if (rxdata != CH_CR && rxdata != CH_LF) begin
                        state_d = ERR_DRAIN;
                    end
                end
            end
            RX_D1: begin
                timed = 1'b1;
                if (rdsig) begin
                    hi_d    = dec[3:0];
                    state_d = dec[4] ? RX_D2 : ERR_DRAIN;
                end
            end
            RX_D2: begin
                timed = 1'b1;
                if (rdsig) begin
                    val_d   = {hi_q, dec[3:0]};
                    state_d = dec[4] ? RX_CR : ERR_DRAIN;
                end
            end
            RX_CR: begin
                timed = 1'b1;
                if (rdsig) begin
                    if (rxdata == CH_CR) begin
                        bright_d    = val_q;
                        cmd_valid_d = 1'b1;
                        resp_d      = {CH_LF, CH_CR, 8'h4B, 8'h4F};
                        idx_d       = 2'd0;
                        state_d     = TX_LOAD;
                    end else begin
                        state_d = ERR_DRAIN;
                    end
                end
            end
            Q_CR: begin
                timed = 1'b1;
                if (rdsig) begin
                    if (rxdata == CH_CR) begin
                        resp_d  = {CH_LF, CH_CR, hex_chr(bright_q[3:0]), hex_chr(bright_q[7:4])};
                        idx_d   = 2'd0;
                        state_d = TX_LOAD;
                    end else begin
                        state_d = ERR_DRAIN;
                    end
                end
            end
            ERR_DRAIN: begin
                timed = 1'b1;
                if (rdsig && rxdata == CH_CR) begin
                    resp_d  = {CH_LF, CH_CR, 8'h52, 8'h45};
                    idx_d   = 2'd0;
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (!tx_busy) begin
                    wrsig_d  = 1'b1;
                    txdata_d = resp_q[idx_q];
                    state_d  = TX_WAIT_BUSY;
                end
            end
            TX_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = TX_WAIT_DONE;
                end
            end
            TX_WAIT_DONE: begin
                if (!tx_busy) begin
                    idx_d   = idx_q + 2'd1;
                    state_d = (idx_q == 2'd3) ? RX_IDLE : TX_LOAD;
                end
            end
            default: state_d = RX_IDLE;
        endcase

        // Inactivity timeout overrides the parser: abandon the partial command silently
        if (timed) begin
            if (rdsig) begin
                cnt_d = 16'd0;
            end else if (cnt_q >= TIMEOUT) begin
                cnt_d   = 16'd0;
                state_d = RX_IDLE;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    assign wrsig      = wrsig_q;
    assign txdata     = txdata_q;
    assign brightness = bright_q;
    assign cmd_valid  = cmd_valid_q;

endmodule

// File: tb/tb_bright_cmd_ctrl.sv
// Scoreboard bench for bright_cmd_ctrl: expected tx bytes and brightness updates are
// queued by the stimulus and consumed by a monitor on each wrsig / cmd_valid pulse.
module tb_bright_cmd_ctrl;

    localparam int unsigned TIMEOUT_CYC = 15360;

    logic       clk = 1'b0;
    logic       rst;
    logic       rdsig;
    logic [7:0] rxdata;
    logic       tx_busy;
    logic       wrsig;
    logic [7:0] txdata;
    logic [7:0] brightness;
    logic       cmd_valid;

    int checks   = 0;
    int errors   = 0;
    int wr_count = 0;
    int cv_count = 0;
    int busy_len = 100;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_cv[$];

    bright_cmd_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .rdsig      (rdsig),
        .rxdata     (rxdata),
        .tx_busy    (tx_busy),
        .wrsig      (wrsig),
        .txdata     (txdata),
        .brightness (brightness),
        .cmd_valid  (cmd_valid)
    );

    always #5 clk = ~clk;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every wrsig / cmd_valid pulse consumes one scoreboard entry
    always @(negedge clk) begin
        if (!rst) begin
            if (wrsig) begin
                wr_count++;
                check_int("wrsig_while_busy", int'(tx_busy), 0);
                if (exp_tx.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_wrsig: got txdata %h expected no transmission", txdata);
                end else begin
                    check8("txdata", txdata, exp_tx.pop_front());
                end
            end
            if (cmd_valid) begin
                cv_count++;
                if (exp_cv.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_cmd_valid: got brightness %h expected no update", brightness);
                end else begin
                    check8("cmd_brightness", brightness, exp_cv.pop_front());
                end
            end
        end
    end

    // UART transmitter model: busy for busy_len cycles after each accepted wrsig
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (wrsig && !rst) begin
                #1 tx_busy = 1'b1;
                repeat (busy_len) @(negedge clk);
                #1 tx_busy = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] b);
        @(posedge clk);
        #1;
        rxdata = b;
        rdsig  = 1'b1;
        @(posedge clk);
        #1;
        rdsig = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic expect_resp(input string s);
        for (int i = 0; i < s.len(); i++) exp_tx.push_back(s[i]);
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h0A);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || tx_busy) && n < 4000) begin
            @(posedge clk);
            n++;
        end
        check_int({name, "_response_timeout"}, int'(n >= 4000), 0);
        repeat (5) @(posedge clk);
    endtask

    task automatic wait_wr(input int target);
        int n;
        n = 0;
        while (wr_count < target && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check_int("wait_wrsig_timeout", int'(n >= 3000), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst    = 1'b1;
        rdsig  = 1'b0;
        rxdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check8("rst_brightness", brightness, 8'h80);
        check8("rst_wrsig", {7'd0, wrsig}, 8'h00);
        check8("rst_txdata", txdata, 8'h00);
        check8("rst_cmd_valid", {7'd0, cmd_valid}, 8'h00);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Bad hex digit -> ER, brightness untouched
        expect_resp("ER");
        send_str("BG1"); send(8'h0D);
        wait_done("bad_hex");
        check8("bad_hex_brightness", brightness, 8'h80);

        // Set 3F with lowercase digit
        exp_cv.push_back(8'h3F);
        expect_resp("OK");
        send_str("B3f"); send(8'h0D);
        wait_done("set_3f");
        check8("set_3f_brightness", brightness, 8'h3F);

        // Query, with a full set command injected while the response is on the wire
        base = wr_count;
        expect_resp("3F");
        send_str("?"); send(8'h0D);
        wait_wr(base + 1);
        send_str("B00"); send(8'h0D);
        wait_done("query_3f");
        check_int("query_wrsig_count", wr_count - base, 4);
        check8("query_brightness", brightness, 8'h3F);

        // CR/LF ignored in idle; gap shorter than the timeout keeps the command alive
        send(8'h0A); send(8'h0D);
        exp_cv.push_back(8'hA5);
        expect_resp("OK");
        send_str("bA");
        repeat (200) @(posedge clk);
        send_str("5"); send(8'h0D);
        wait_done("set_a5");
        check8("set_a5_brightness", brightness, 8'hA5);

        expect_resp("A5");
        send_str("?"); send(8'h0D);
        wait_done("query_a5");

        // Missing CR after digits, drained until CR
        expect_resp("ER");
        send_str("B12XZ"); send(8'h0D);
        wait_done("no_cr");
        check8("no_cr_brightness", brightness, 8'hA5);

        // Unknown command byte in idle
        expect_resp("ER");
        send_str("Q"); send(8'h0D);
        wait_done("bad_cmd");

        // Setting the same value still pulses cmd_valid
        base = cv_count;
        exp_cv.push_back(8'hA5);
        expect_resp("OK");
        send_str("BA5"); send(8'h0D);
        wait_done("same_val");
        check_int("same_val_cmd_valid", cv_count - base, 1);

        // Reset after the second response byte abandons the response
        base = wr_count;
        expect_resp("A5");
        send_str("?"); send(8'h0D);
        wait_wr(base + 2);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_tx.delete();
        repeat (3) @(posedge clk);
        #1;
        check8("midtx_rst_brightness", brightness, 8'h80);
        check8("midtx_rst_wrsig", {7'd0, wrsig}, 8'h00);
        rst = 1'b0;
        repeat (400) @(posedge clk);
        check_int("post_rst_wrsig_count", wr_count - base, 2);

        // Partial command abandoned silently after the inactivity timeout
        send_str("B1");
        repeat (TIMEOUT_CYC + 50) @(posedge clk);
        expect_resp("80");
        send_str("?"); send(8'h0D);
        wait_done("timeout_query");
        check8("timeout_brightness", brightness, 8'h80);

        // Normal set after reset recovery
        exp_cv.push_back(8'h3F);
        expect_resp("OK");
        send_str("B3f"); send(8'h0D);
        wait_done("set_after_rst");
        check8("set_after_rst_brightness", brightness, 8'h3F);

        check_int("tx_queue_drained", exp_tx.size(), 0);
        check_int("cv_queue_drained", exp_cv.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
